hpdmc_ddr_wrseq: RTL

Write-burst sequencer for the 16-bit DDR SDRAM PHY.
- Takes one write-burst command from the HPDMC command layer.
- Produces the per-clock D0/D1 data pairs, DQS pattern and output-enable controls that feed the DDR output flip-flop primitives (DQ, DM, DQS).
- Guarantees DQS preamble/postamble framing and that DQ and DQS are aligned for each burst.

---
 rtl/hpdmc_ddr_wrseq_if.sv | 34 +++
 rtl/hpdmc_ddr_wrseq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_ddr_wrseq_if.sv
// Write-burst sequencer bus: command handshake, write-data stream and the
// D0/D1/OE controls that feed the DQ, DM and DQS output flip-flops.
interface hpdmc_ddr_wrseq_if;
    logic        start;
    logic        ready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wdata_valid;
    logic        wdata_ack;
    logic [15:0] dq_d0;
    logic [15:0] dq_d1;
    logic [1:0]  dm_d0;
    logic [1:0]  dm_d1;
    logic        dq_oe;
    logic        dqs_d0;
    logic        dqs_d1;
    logic        dqs_oe;
    logic        done;
    logic        underrun;

    // Sequencer side
    modport slave (
        input  start, wdata, wmask, wdata_valid,
        output ready, wdata_ack, dq_d0, dq_d1, dm_d0, dm_d1,
               dq_oe, dqs_d0, dqs_d1, dqs_oe, done, underrun
    );

    // Command/data source and PHY side
    modport master (
        output start, wdata, wmask, wdata_valid,
        input  ready, wdata_ack, dq_d0, dq_d1, dm_d0, dm_d1,
               dq_oe, dqs_d0, dqs_d1, dqs_oe, done, underrun
    );
endinterface

// File: rtl/hpdmc_ddr_wrseq.sv
// DDR write-burst sequencer for the 16-bit PHY.
// Accepts one burst command, waits WRITE_LATENCY cycles, then frames the
// burst with a one-cycle DQS preamble, BURST_LEN/2 data cycles and a
// one-cycle postamble. Output registers lag the FSM state by one cycle.
// Optional feature macro: HPDMC_WR_DM_EN (drive DM from wmask and mask
// underrun beats); when undefined the DM outputs are constant 0.
module hpdmc_ddr_wrseq #(
    parameter int BURST_LEN     = 4,
    parameter int WRITE_LATENCY = 1
) (
    input logic              sys_clk,
    input logic              sys_rst,
    hpdmc_ddr_wrseq_if.slave bus
);

    localparam int NBEATS = BURST_LEN / 2;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
    localparam logic [2:0]        WAIT_LOAD = 3'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PRE,
        S_DATA,
        S_POST
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        wait_q, wait_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    logic [15:0] dq_d0_q, dq_d0_d;
    logic [15:0] dq_d1_q, dq_d1_d;
    logic        dq_oe_q, dq_oe_d;
    logic        dqs_d0_q, dqs_d0_d;
    logic        dqs_oe_q, dqs_oe_d;
    logic        done_q, done_d;
    logic        underrun_q, underrun_d;

    logic in_data;
    logic beat_underrun;

    assign in_data       = (state_q == S_DATA);
    assign beat_underrun = in_data && !bus.wdata_valid;

    // Next-state logic: accept only from IDLE, then WAIT/PRE/DATA/POST.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (WRITE_LATENCY > 0) begin
                        state_d = S_WAIT;
                        wait_d  = WAIT_LOAD;
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == 3'd0) state_d = S_PRE;
                else                wait_d  = wait_q - 3'd1;
            end
            S_PRE: begin
                state_d = S_DATA;
                beat_d  = '0;
            end
            S_DATA: begin
                if (beat_q == LAST_BEAT) state_d = S_POST;
                else                     beat_d  = beat_q + 1'b1;
            end
            S_POST:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output register inputs decoded from the current state.
    always_comb begin
        dqs_oe_d   = 1'b0;
        dqs_d0_d   = 1'b0;
        dq_oe_d    = 1'b0;
        done_d     = 1'b0;
        dq_d0_d    = dq_d0_q;
        dq_d1_d    = dq_d1_q;
        underrun_d = underrun_q | beat_underrun;
        case (state_q)
            S_PRE: dqs_oe_d = 1'b1;
            S_DATA: begin
                dqs_oe_d = 1'b1;
                dqs_d0_d = 1'b1;
                dq_oe_d  = 1'b1;
                dq_d0_d  = bus.wdata[15:0];
                dq_d1_d  = bus.wdata[31:16];
            end
            S_POST: begin
                dqs_oe_d = 1'b1;
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (sys_rst) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            beat_q     <= '0;
            dq_d0_q    <= '0;
            dq_d1_q    <= '0;
            dq_oe_q    <= 1'b0;
            dqs_d0_q   <= 1'b0;
            dqs_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            beat_q     <= beat_d;
            dq_d0_q    <= dq_d0_d;
            dq_d1_q    <= dq_d1_d;
            dq_oe_q    <= dq_oe_d;
            dqs_d0_q   <= dqs_d0_d;
            dqs_oe_q   <= dqs_oe_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef HPDMC_WR_DM_EN
    logic [1:0] dm_d0_q, dm_d0_d;
    logic [1:0] dm_d1_q, dm_d1_d;

    // DM follows wmask on data beats; an underrun beat is fully masked.
    always_comb begin
        dm_d0_d = dm_d0_q;
        dm_d1_d = dm_d1_q;
        if (in_data) begin
            dm_d0_d = beat_underrun ? 2'b11 : bus.wmask[1:0];
            dm_d1_d = beat_underrun ? 2'b11 : bus.wmask[3:2];
        end
    end

    // DM output registers, cleared by reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dm_d0_q <= 2'b00;
            dm_d1_q <= 2'b00;
        end else begin
            dm_d0_q <= dm_d0_d;
            dm_d1_q <= dm_d1_d;
        end
    end

    assign bus.dm_d0 = dm_d0_q;
    assign bus.dm_d1 = dm_d1_q;
`else
    logic unused_wmask;
    assign unused_wmask = ^bus.wmask;
    assign bus.dm_d0    = 2'b00;
    assign bus.dm_d1    = 2'b00;
`endif

    assign bus.ready     = (state_q == S_IDLE);
    assign bus.wdata_ack = in_data;
    assign bus.dq_d0     = dq_d0_q;
    assign bus.dq_d1     = dq_d1_q;
    assign bus.dq_oe     = dq_oe_q;
    assign bus.dqs_d0    = dqs_d0_q;
    assign bus.dqs_d1    = 1'b0;
    assign bus.dqs_oe    = dqs_oe_q;
    assign bus.done      = done_q;
    assign bus.underrun  = underrun_q;

endmodule
